// File: rtl/rr_mux_arbiter_4x1_if.sv
// rr_mux_arbiter_4x1_if: requester-side and output-side valid/ready bundle for the 4:1 arbiter
interface rr_mux_arbiter_4x1_if #(
  parameter int WIDTH = 8
);
  logic [3:0]       in_valid, in_last, in_ready;
  logic [WIDTH-1:0] in0, in1, in2, in3, out_data;
  logic             out_valid, out_ready, out_last;
  logic [1:0]       out_id;
  modport master (
    output in_valid, in_last, in0, in1, in2, in3, out_ready,
    input  in_ready, out_valid, out_data, out_last, out_id
  );
  modport slave (
    input  in_valid, in_last, in0, in1, in2, in3, out_ready,
    output in_ready, out_valid, out_data, out_last, out_id
  );
endinterface

// File: rtl/rr_mux_arbiter_4x1.sv
// rr_mux_arbiter_4x1: packet-aware round-robin 4:1 arbiter with a one-entry registered output stage
module rr_mux_arbiter_4x1 #(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  rr_mux_arbiter_4x1_if.slave bus
);
  typedef enum logic {ARB, LOCK} state_t;
  state_t           state_q, state_d;
  logic [1:0]       ptr_q, ptr_d, owner_q, owner_d, id_q, id_d, cand, idx, sel;
  logic [WIDTH-1:0] data_q, data_d, mux;
  logic             valid_q, valid_d, last_q, last_d, found, load_en, grant, acc;
  // descending scan so the requester closest to ptr wins
  always_comb begin
    cand = ptr_q;
    found = 1'b0;
    idx = ptr_q;
    for (int k = 3; k >= 0; k--) begin
      idx = ptr_q + 2'(k);
      if (bus.in_valid[idx]) begin
        cand = idx;
        found = 1'b1;
      end
    end
  end
  always_comb begin
    load_en = !valid_q || bus.out_ready;
    sel = (state_q == LOCK) ? owner_q : cand;
    grant = rst_n && load_en && (state_q == LOCK || found);
    acc = grant && bus.in_valid[sel];
    mux = sel == 2'd0 ? bus.in0 : sel == 2'd1 ? bus.in1 : sel == 2'd2 ? bus.in2 : bus.in3;
    valid_d = load_en ? acc : valid_q;
    data_d = acc ? mux : data_q;
    last_d = acc ? bus.in_last[sel] : last_q;
    id_d = acc ? sel : id_q;
    owner_d = acc ? sel : owner_q;
    state_d = acc ? (bus.in_last[sel] ? ARB : LOCK) : state_q;
    ptr_d = (acc && bus.in_last[sel]) ? sel + 2'd1 : ptr_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB;
      ptr_q <= '0;
      owner_q <= '0;
      valid_q <= 1'b0;
      data_q <= '0;
      last_q <= 1'b0;
      id_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      owner_q <= owner_d;
      valid_q <= valid_d;
      data_q <= data_d;
      last_q <= last_d;
      id_q <= id_d;
    end
  end
  assign bus.in_ready = grant ? (4'b0001 << sel) : 4'b0000;
  assign bus.out_valid = valid_q;
  assign bus.out_data = data_q;
  assign bus.out_last = last_q;
  assign bus.out_id = id_q;
endmodule

// File: tb/tb_rr_mux_arbiter_4x1.sv
// tb_rr_mux_arbiter_4x1: table-driven cycle vectors with an output-beat scoreboard
module tb_rr_mux_arbiter_4x1;
  typedef struct packed {
    logic [3:0]      v;
    logic [3:0]      l;
    logic [3:0][7:0] d;
    logic            ordy;
    logic [3:0]      er;
    logic            eov;
  } vec_t;
  typedef struct packed {
    logic [7:0] data;
    logic       last;
    logic [1:0] id;
  } beat_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  vec_t tbl[$];
  beat_t sb[$];
  rr_mux_arbiter_4x1_if #(.WIDTH(8)) bus ();
  rr_mux_arbiter_4x1 #(.WIDTH(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic add(input logic [3:0] v, input logic [3:0] l, input logic [7:0] d0, input logic [7:0] d1,
                     input logic [7:0] d2, input logic [7:0] d3, input logic ordy, input logic [3:0] er,
                     input logic eov);
    vec_t t;
    t.v = v;
    t.l = l;
    t.d = {d3, d2, d1, d0};
    t.ordy = ordy;
    t.er = er;
    t.eov = eov;
    tbl.push_back(t);
  endtask
  task automatic run(input vec_t t, input string tag);
    beat_t b;
    @(negedge clk);
    bus.in_valid = t.v;
    bus.in_last = t.l;
    bus.in0 = t.d[0];
    bus.in1 = t.d[1];
    bus.in2 = t.d[2];
    bus.in3 = t.d[3];
    bus.out_ready = t.ordy;
    #1;
    chk({tag, " in_ready"}, 32'(bus.in_ready), 32'(t.er));
    chk({tag, " out_valid"}, 32'(bus.out_valid), 32'(t.eov));
    if (bus.out_valid) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL %s sb_empty: got beat %0h with no expected beat", tag, bus.out_data);
      end else begin
        chk({tag, " out_data"}, 32'(bus.out_data), 32'(sb[0].data));
        chk({tag, " out_last"}, 32'(bus.out_last), 32'(sb[0].last));
        chk({tag, " out_id"}, 32'(bus.out_id), 32'(sb[0].id));
        if (bus.out_ready) void'(sb.pop_front());
      end
    end
    for (int i = 0; i < 4; i++)
      if (t.v[i] && t.er[i]) begin
        b.data = t.d[i];
        b.last = t.l[i];
        b.id = 2'(i);
        sb.push_back(b);
      end
  endtask
  initial begin
    vec_t t;
    bus.in_valid = 4'b1111;
    bus.in_last = 4'b1111;
    bus.in0 = 8'h10;
    bus.in1 = 8'h11;
    bus.in2 = 8'h12;
    bus.in3 = 8'h13;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst in_ready", 32'(bus.in_ready), 32'h0);
    chk("rst out_valid", 32'(bus.out_valid), 32'h0);
    chk("rst out_data", 32'(bus.out_data), 32'h0);
    chk("rst out_last", 32'(bus.out_last), 32'h0);
    chk("rst out_id", 32'(bus.out_id), 32'h0);
    bus.in_valid = 4'b0000;
    @(negedge clk);
    rst_n = 1'b1;
    // rotation 0,1,2,3,0 with single-beat packets
    add(4'b1111, 4'b1111, 8'h10, 8'h11, 8'h12, 8'h13, 1, 4'b0001, 0);
    add(4'b1111, 4'b1111, 8'h10, 8'h11, 8'h12, 8'h13, 1, 4'b0010, 1);
    add(4'b1111, 4'b1111, 8'h10, 8'h11, 8'h12, 8'h13, 1, 4'b0100, 1);
    add(4'b1111, 4'b1111, 8'h10, 8'h11, 8'h12, 8'h13, 1, 4'b1000, 1);
    add(4'b1111, 4'b1111, 8'h10, 8'h11, 8'h12, 8'h13, 1, 4'b0001, 1);
    add(4'b0000, 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1, 4'b0000, 1);
    // ptr=1: requester 1 locks for 3 beats while 0 and 3 wait, then 3, then 0
    add(4'b1011, 4'b1001, 8'h30, 8'h21, 8'h00, 8'h33, 1, 4'b0010, 0);
    add(4'b1011, 4'b1001, 8'h30, 8'h22, 8'h00, 8'h33, 1, 4'b0010, 1);
    add(4'b1011, 4'b1011, 8'h30, 8'h23, 8'h00, 8'h33, 1, 4'b0010, 1);
    add(4'b1001, 4'b1001, 8'h30, 8'h00, 8'h00, 8'h33, 1, 4'b1000, 1);
    add(4'b0001, 4'b0001, 8'h30, 8'h00, 8'h00, 8'h00, 1, 4'b0001, 1);
    add(4'b0000, 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1, 4'b0000, 1);
    // ptr=1: backpressure on 0xA5, consume and reload in the same cycle
    add(4'b0100, 4'b0100, 8'h00, 8'h00, 8'hA5, 8'h00, 0, 4'b0100, 0);
    add(4'b0001, 4'b0001, 8'h0B, 8'h00, 8'h00, 8'h00, 0, 4'b0000, 1);
    add(4'b0001, 4'b0001, 8'h0B, 8'h00, 8'h00, 8'h00, 0, 4'b0000, 1);
    add(4'b0001, 4'b0001, 8'h0B, 8'h00, 8'h00, 8'h00, 0, 4'b0000, 1);
    add(4'b0001, 4'b0001, 8'h0B, 8'h00, 8'h00, 8'h00, 1, 4'b0001, 1);
    add(4'b0000, 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1, 4'b0000, 1);
    // ptr=1: owner 0 bubbles for 2 cycles while requester 1 waits
    add(4'b0001, 4'b0000, 8'h40, 8'h00, 8'h00, 8'h00, 1, 4'b0001, 0);
    add(4'b0010, 4'b0010, 8'h00, 8'h50, 8'h00, 8'h00, 1, 4'b0001, 1);
    add(4'b0010, 4'b0010, 8'h00, 8'h50, 8'h00, 8'h00, 1, 4'b0001, 0);
    add(4'b0011, 4'b0011, 8'h41, 8'h50, 8'h00, 8'h00, 1, 4'b0001, 0);
    add(4'b0010, 4'b0010, 8'h00, 8'h50, 8'h00, 8'h00, 1, 4'b0010, 1);
    add(4'b0000, 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1, 4'b0000, 1);
    // ptr=2: packet from 2 puts ptr at 3, then 3 wins over 0, then 0
    add(4'b0100, 4'b0100, 8'h00, 8'h00, 8'h60, 8'h00, 1, 4'b0100, 0);
    add(4'b1001, 4'b1001, 8'h70, 8'h00, 8'h00, 8'h73, 1, 4'b1000, 1);
    add(4'b0001, 4'b0001, 8'h70, 8'h00, 8'h00, 8'h00, 1, 4'b0001, 1);
    add(4'b0000, 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1, 4'b0000, 1);
    add(4'b0100, 4'b0000, 8'h00, 8'h00, 8'h80, 8'h00, 1, 4'b0100, 0);
    for (int i = 0; i < tbl.size(); i++) run(tbl[i], $sformatf("vec%0d", i));
    // reset during the second beat of the packet from requester 2
    @(negedge clk);
    bus.in2 = 8'h81;
    #1;
    chk("mid in_ready", 32'(bus.in_ready), 32'b0100);
    chk("mid out_valid", 32'(bus.out_valid), 32'h1);
    chk("mid out_data", 32'(bus.out_data), 32'h80);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst out_valid", 32'(bus.out_valid), 32'h0);
    chk("mid_rst in_ready", 32'(bus.in_ready), 32'h0);
    chk("mid_rst out_id", 32'(bus.out_id), 32'h0);
    sb.delete();
    bus.in_valid = 4'b0000;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    t = '0;
    t.v = 4'b0101;
    t.l = 4'b0101;
    t.d[0] = 8'h90;
    t.d[2] = 8'h81;
    t.ordy = 1'b1;
    t.er = 4'b0001;
    run(t, "post_rst grant");
    t = '0;
    t.ordy = 1'b1;
    t.eov = 1'b1;
    run(t, "post_rst out");
    t.eov = 1'b0;
    run(t, "post_rst idle");
    chk("sb drained", 32'(sb.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
